vram_dma_reader: RTL and testbench

- DMA engine upstream of the PPU. On a start pulse from the PPU FSM, it copies one full VRAM image from HPS SDRAM into the CPU-facing VRAM write port, then pulses finish back to the PPU.
- It is an Avalon-MM burst read master on the FPGA-SDRAM bridge and a single-port writer into CPU-facing VRAM.
- The PPU only starts it outside the vram_sync_writer sync window, so no arbitration is needed here.

---
 rtl/vram_dma_reader_if.sv | 39 +++
 rtl/vram_dma_reader.sv | 113 +++++++++++
 tb/tb_vram_dma_reader.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_dma_reader_if.sv
// Avalon-MM burst read bus plus the CPU-facing VRAM write port
// driven by the VRAM DMA reader.
interface vram_dma_reader_if #(
    parameter int ADDR_W = 12
);
    logic [31:0]       avm_address;
    logic              avm_read;
    logic [6:0]        avm_burstcount;
    logic              avm_waitrequest;
    logic [127:0]      avm_readdata;
    logic              avm_readdatavalid;
    logic [ADDR_W-1:0] vram_wraddr;
    logic              vram_wren;
    logic [127:0]      vram_wrdata;

    modport master (
        output avm_address,
        output avm_read,
        output avm_burstcount,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid,
        output vram_wraddr,
        output vram_wren,
        output vram_wrdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        input  avm_burstcount,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid,
        input  vram_wraddr,
        input  vram_wren,
        input  vram_wrdata
    );
endinterface

// File: rtl/vram_dma_reader.sv
// Copies one VRAM image from HPS SDRAM into CPU-facing VRAM using
// single-outstanding Avalon bursts, then pulses finish to the PPU.
module vram_dma_reader #(
    parameter int VRAM_WORDS = 4096,
    parameter int BURST_LEN  = 16,
    parameter int ADDR_W     = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        src_addr,
    output logic               busy,
    output logic               finish,
    vram_dma_reader_if.master  bus
);
    localparam int CW = $clog2(VRAM_WORDS + 1);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] WORDS = CW'(VRAM_WORDS);
    localparam logic [BW-1:0] BEATS = BW'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        DONE
    } state_t;

    state_t            state;
    logic [31:0]       base;
    logic [CW-1:0]     wcnt;
    logic [BW-1:0]     bcnt;
    logic [CW-1:0]     wcnt_nxt;
    logic [BW-1:0]     bcnt_nxt;
    logic [31:0]       avm_address;
    logic              avm_read;
    logic [ADDR_W-1:0] vram_wraddr;
    logic              vram_wren;
    logic [127:0]      vram_wrdata;

    assign wcnt_nxt = wcnt + CW'(1);
    assign bcnt_nxt = bcnt + BW'(1);

    assign bus.avm_address    = avm_address;
    assign bus.avm_read       = avm_read;
    assign bus.avm_burstcount = 7'(BURST_LEN);
    assign bus.vram_wraddr    = vram_wraddr;
    assign bus.vram_wren      = vram_wren;
    assign bus.vram_wrdata    = vram_wrdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            base        <= '0;
            wcnt        <= '0;
            bcnt        <= '0;
            busy        <= 1'b0;
            finish      <= 1'b0;
            avm_read    <= 1'b0;
            avm_address <= '0;
            vram_wren   <= 1'b0;
            vram_wraddr <= '0;
            vram_wrdata <= '0;
        end else begin
            finish    <= 1'b0;
            vram_wren <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base        <= {src_addr[31:4], 4'h0};
                        avm_address <= {src_addr[31:4], 4'h0};
                        avm_read    <= 1'b1;
                        wcnt        <= '0;
                        bcnt        <= '0;
                        busy        <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (!bus.avm_waitrequest) begin
                        avm_read <= 1'b0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    // readdatavalid only counts here; stray beats elsewhere drop
                    if (bus.avm_readdatavalid) begin
                        vram_wren   <= 1'b1;
                        vram_wrdata <= bus.avm_readdata;
                        vram_wraddr <= ADDR_W'(wcnt);
                        wcnt        <= wcnt_nxt;
                        bcnt        <= bcnt_nxt;
                        if (bcnt_nxt == BEATS) begin
                            if (wcnt_nxt == WORDS) begin
                                state <= DONE;
                            end else begin
                                bcnt        <= '0;
                                avm_read    <= 1'b1;
                                avm_address <= base + (32'(wcnt_nxt) << 4);
                                state       <= REQ;
                            end
                        end
                    end
                end
                DONE: begin
                    busy   <= 1'b0;
                    finish <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_dma_reader.sv
// Directed bench: small instance (32 words, burst 8) and default
// instance (4096 words, burst 16) sharing one Avalon slave model.
module tb_vram_dma_reader;
    logic        clk;
    logic        rst;
    logic        start_s;
    logic        start_b;
    logic [31:0] src;
    logic        sel;
    logic        busy_s, finish_s, busy_b, finish_b;

    logic         wr;
    logic         rv;
    logic [127:0] rd;

    vram_dma_reader_if #(.ADDR_W(12)) bs ();
    vram_dma_reader_if #(.ADDR_W(12)) bb ();

    assign bs.avm_waitrequest   = wr;
    assign bs.avm_readdata      = rd;
    assign bs.avm_readdatavalid = rv;
    assign bb.avm_waitrequest   = wr;
    assign bb.avm_readdata      = rd;
    assign bb.avm_readdatavalid = rv;

    vram_dma_reader #(.VRAM_WORDS(32), .BURST_LEN(8), .ADDR_W(12)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .src_addr(src),
        .busy(busy_s), .finish(finish_s), .bus(bs)
    );

    vram_dma_reader #(.VRAM_WORDS(4096), .BURST_LEN(16), .ADDR_W(12)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .src_addr(src),
        .busy(busy_b), .finish(finish_b), .bus(bb)
    );

    logic         m_read, m_wren, m_busy, m_fin;
    logic [31:0]  m_addr;
    logic [6:0]   m_bc;
    logic [11:0]  m_wa;
    logic [127:0] m_wd;

    assign m_read = sel ? bb.avm_read : bs.avm_read;
    assign m_addr = sel ? bb.avm_address : bs.avm_address;
    assign m_bc   = sel ? bb.avm_burstcount : bs.avm_burstcount;
    assign m_wren = sel ? bb.vram_wren : bs.vram_wren;
    assign m_wa   = sel ? bb.vram_wraddr : bs.vram_wraddr;
    assign m_wd   = sel ? bb.vram_wrdata : bs.vram_wrdata;
    assign m_busy = sel ? busy_b : busy_s;
    assign m_fin  = sel ? finish_b : finish_s;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int pend, gap, bursts, beats, stall_burst, stall_left;
    bit stall_seen, gap_mode, stray;
    logic [31:0] baddr;
    logic [31:0] bq[$];
    logic [31:0] st_addr[$];
    logic        st_read[$];

    logic [11:0]  wa[$];
    logic [127:0] wd[$];
    int fin_cnt, fin_busy, fin_cyc, last_wr_cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Avalon slave: zero-latency accept, data = byte address of the beat
    initial begin
        wr = 1'b0; rv = 1'b0; rd = '0;
        pend = 0; gap = 0; stall_left = 0;
        forever begin
            @(negedge clk);
            rv = 1'b0;
            wr = 1'b0;
            if (rst) begin
                pend = 0; gap = 0; stall_left = 0;
            end else begin
                if (pend > 0) begin
                    if (gap > 0) gap--;
                    else begin
                        rv = 1'b1;
                        rd = {96'h0, baddr};
                        baddr += 32'd16;
                        pend--;
                        beats++;
                        gap = gap_mode ? int'($urandom_range(3, 0)) : 0;
                    end
                end else if (stray) begin
                    rv = 1'b1;
                    rd = 128'hDEAD_BEEF;
                end
                if (stall_left > 0) begin
                    wr = 1'b1;
                    st_addr.push_back(m_addr);
                    st_read.push_back(m_read);
                    stall_left--;
                end else if (m_read && pend == 0) begin
                    if (bursts == stall_burst && !stall_seen) begin
                        stall_seen = 1'b1;
                        stall_left = 4;
                        wr = 1'b1;
                        st_addr.push_back(m_addr);
                        st_read.push_back(m_read);
                    end else begin
                        bq.push_back(m_addr);
                        baddr = m_addr;
                        pend = int'(m_bc);
                        bursts++;
                        gap = gap_mode ? int'($urandom_range(3, 0)) : 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (m_wren) begin
                    wa.push_back(m_wa);
                    wd.push_back(m_wd);
                    last_wr_cyc = cyc;
                end
                if (m_fin) begin
                    fin_cnt++;
                    fin_cyc = cyc;
                    if (m_busy) fin_busy++;
                end
            end
        end
    end

    task automatic clear_logs();
        bq.delete(); st_addr.delete(); st_read.delete();
        wa.delete(); wd.delete();
        bursts = 0; beats = 0; stall_seen = 1'b0;
        fin_cnt = 0; fin_busy = 0; fin_cyc = 0; last_wr_cyc = 0;
    endtask

    task automatic do_start(input logic [31:0] a);
        @(negedge clk);
        src = a;
        if (sel) start_b = 1'b1;
        else start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_finish(input int budget, input string nm);
        int n = 0;
        while (fin_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fin_cnt == 0) begin
            failures++;
            $display("FAIL %s_timeout: no finish within %0d cycles", nm, budget);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy_s !== 1'b0 || finish_s !== 1'b0) begin failures++; $display("FAIL rst_flags: busy=%b finish=%b required 0 0", busy_s, finish_s); end
        checks++; if (bs.avm_read !== 1'b0 || bs.vram_wren !== 1'b0) begin failures++; $display("FAIL rst_strobes: read=%b wren=%b required 0 0", bs.avm_read, bs.vram_wren); end
        checks++; if (bs.avm_address !== 32'h0 || bs.vram_wraddr !== 12'h0 || bs.vram_wrdata !== 128'h0) begin failures++; $display("FAIL rst_regs: addr=%h wraddr=%h wrdata=%h required 0", bs.avm_address, bs.vram_wraddr, bs.vram_wrdata); end
        checks++; if (bs.avm_burstcount !== 7'd8 || bb.avm_burstcount !== 7'd16) begin failures++; $display("FAIL rst_burstcount: got %0d/%0d required 8/16", bs.avm_burstcount, bb.avm_burstcount); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy_s !== 1'b0 || busy_b !== 1'b0 || bs.avm_read !== 1'b0) begin failures++; $display("FAIL post_rst_idle: busy=%b/%b read=%b required 0", busy_s, busy_b, bs.avm_read); end
    endtask

    task automatic test_basic();
        int bad = 0;
        clear_logs();
        do_start(32'h3000_0000);
        checks++; if (busy_s !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b required 1", busy_s); end
        wait_finish(400, "basic");
        checks++; if (bq.size() != 4) begin failures++; $display("FAIL basic_bursts: got %0d required 4", bq.size()); end
        for (int i = 0; i < bq.size(); i++) if (bq[i] !== 32'h3000_0000 + 32'(i * 128)) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL basic_burst_addr: %0d wrong, first=%h required 30000000", bad, bq[0]); end
        bad = 0;
        for (int i = 0; i < wa.size(); i++) if (wa[i] !== 12'(i) || wd[i] !== {96'h0, 32'h3000_0000 + 32'(i * 16)}) bad++;
        checks++; if (wa.size() != 32 || bad != 0) begin failures++; $display("FAIL basic_writes: got %0d writes %0d wrong required 32 0", wa.size(), bad); end
        checks++; if (fin_cnt != 1 || fin_busy != 0) begin failures++; $display("FAIL basic_finish: pulses=%0d busy_at_finish=%0d required 1 0", fin_cnt, fin_busy); end
        checks++; if (fin_cyc != last_wr_cyc + 1) begin failures++; $display("FAIL basic_finish_timing: finish cyc %0d required %0d", fin_cyc, last_wr_cyc + 1); end
        checks++; if (busy_s !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b required 0", busy_s); end
    endtask

    task automatic test_waitrequest();
        int bad = 0;
        clear_logs();
        stall_burst = 1;
        do_start(32'h3000_0000);
        wait_finish(400, "wait");
        stall_burst = -1;
        for (int i = 0; i < st_addr.size(); i++) if (st_addr[i] !== 32'h3000_0080 || st_read[i] !== 1'b1) bad++;
        checks++; if (st_addr.size() != 5 || bad != 0) begin failures++; $display("FAIL wait_stable: %0d stall cycles %0d unstable required 5 0", st_addr.size(), bad); end
        checks++; if (bq.size() != 4 || bq[1] !== 32'h3000_0080) begin failures++; $display("FAIL wait_bursts: got %0d bursts required 4", bq.size()); end
        checks++; if (wa.size() != 32 || fin_cnt != 1) begin failures++; $display("FAIL wait_writes: got %0d writes %0d finish required 32 1", wa.size(), fin_cnt); end
    endtask

    task automatic test_gaps();
        int bad = 0;
        clear_logs();
        gap_mode = 1'b1;
        do_start(32'h3000_0000);
        wait_finish(800, "gaps");
        gap_mode = 1'b0;
        for (int i = 0; i < wa.size(); i++) if (wa[i] !== 12'(i) || wd[i] !== {96'h0, 32'h3000_0000 + 32'(i * 16)}) bad++;
        checks++; if (wa.size() != 32 || bad != 0) begin failures++; $display("FAIL gaps_writes: got %0d writes %0d wrong required 32 0", wa.size(), bad); end
        checks++; if (wa.size() != beats) begin failures++; $display("FAIL gaps_wren_count: got %0d writes for %0d beats", wa.size(), beats); end
    endtask

    task automatic test_unaligned_busy_start();
        int bad = 0;
        int n = 0;
        clear_logs();
        do_start(32'h1234_567F);
        while (fin_cnt == 0 && n < 400) begin
            @(negedge clk);
            n++;
            start_s = (n == 3 || n == 16 || n == 30);
        end
        start_s = 1'b0;
        checks++; if (fin_cnt == 0) begin failures++; $display("FAIL unal_timeout: no finish within 400 cycles"); end
        repeat (12) @(negedge clk);
        checks++; if (bq.size() < 1 || bq[0] !== 32'h1234_5670) begin failures++; $display("FAIL unal_addr: first burst %h required 12345670", bq.size() > 0 ? bq[0] : 32'hx); end
        for (int i = 0; i < wa.size(); i++) if (wa[i] !== 12'(i) || wd[i] !== {96'h0, 32'h1234_5670 + 32'(i * 16)}) bad++;
        checks++; if (wa.size() != 32 || bad != 0) begin failures++; $display("FAIL unal_writes: got %0d writes %0d wrong required 32 0", wa.size(), bad); end
        checks++; if (fin_cnt != 1 || busy_s !== 1'b0) begin failures++; $display("FAIL unal_single_finish: pulses=%0d busy=%b required 1 0", fin_cnt, busy_s); end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        int n = 0;
        clear_logs();
        do_start(32'h3000_0000);
        while (beats < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (beats < 10) begin failures++; $display("FAIL rstmid_timeout: %0d beats required 10", beats); end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_logs();
        stray = 1'b1;
        repeat (6) @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (wa.size() != 0 || fin_cnt != 0 || busy_s !== 1'b0) begin failures++; $display("FAIL rstmid_stray: writes=%0d finish=%0d busy=%b required 0 0 0", wa.size(), fin_cnt, busy_s); end
        clear_logs();
        do_start(32'h3000_0000);
        wait_finish(400, "rstmid");
        for (int i = 0; i < wa.size(); i++) if (wa[i] !== 12'(i) || wd[i] !== {96'h0, 32'h3000_0000 + 32'(i * 16)}) bad++;
        checks++; if (wa.size() != 32 || bad != 0 || fin_cnt != 1) begin failures++; $display("FAIL rstmid_rerun: %0d writes %0d wrong %0d finish required 32 0 1", wa.size(), bad, fin_cnt); end
    endtask

    task automatic test_default();
        int bad = 0;
        sel = 1'b1;
        clear_logs();
        do_start(32'h0);
        wait_finish(8000, "default");
        for (int i = 0; i < wa.size(); i++) if (wa[i] !== 12'(i) || wd[i] !== {96'h0, 32'(i * 16)}) bad++;
        checks++; if (bq.size() != 256) begin failures++; $display("FAIL dflt_bursts: got %0d required 256", bq.size()); end
        checks++; if (wa.size() != 4096 || bad != 0) begin failures++; $display("FAIL dflt_writes: got %0d writes %0d wrong required 4096 0", wa.size(), bad); end
        checks++; if (wa.size() == 0 || wa[wa.size() - 1] !== 12'd4095) begin failures++; $display("FAIL dflt_last_addr: got %0d required 4095", wa.size() > 0 ? wa[wa.size() - 1] : 12'hx); end
        checks++; if (fin_cnt != 1 || fin_cyc != last_wr_cyc + 1) begin failures++; $display("FAIL dflt_finish: pulses=%0d cyc=%0d required 1 %0d", fin_cnt, fin_cyc, last_wr_cyc + 1); end
        checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL dflt_busy_after: got %b required 0", busy_b); end
        sel = 1'b0;
    endtask

    initial begin
        start_s = 1'b0; start_b = 1'b0; src = '0; sel = 1'b0;
        gap_mode = 1'b0; stray = 1'b0; stall_burst = -1;
        clear_logs();
        test_reset();
        test_basic();
        test_waitrequest();
        test_gaps();
        test_unaligned_busy_start();
        test_reset_mid();
        test_default();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
